// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc
// Parametrised reverse-Polish stack calculator with a valid/ready command port
// and a sequential shift-add multiplier.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   nrst   - asynchronous active-low reset
//   valid  - command present this cycle
//   ready  - block can accept a command (low while a MUL is in progress)
//   push   - 1: push d, 0: execute op
//   op     - opcode (NOP NEG ADD MUL SUB DUP SWAP DROP)
//   d      - push operand
//   out    - registered copy of the top of stack, 0 when empty
//   cnt    - number of entries on the stack
//   err    - sticky error, set by any rejected command, cleared by reset

module rpn_stack_calc #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             valid,
  output logic             ready,
  input  logic             push,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out,
  output logic [CW-1:0]    cnt,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_NEG  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_DUP  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_DROP = 3'b111;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state;

  // T lives in a register; mem[0 .. cnt-2] holds the entries beneath it, so
  // S is always mem[cnt-2] and pushing moves the old T into mem[cnt-1].
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] s_val;
  logic [AW-1:0]    t_idx;
  logic [AW-1:0]    s_idx;

  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [SW-1:0]    step;

  logic             accept;
  logic             reject;
  logic             full;
  logic             empty;

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  assign ready  = (state == IDLE);
  assign accept = valid && ready;
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign t_idx  = AW'(cnt - CW'(1));
  assign s_idx  = AW'(cnt - CW'(2));
  assign s_val  = mem[s_idx];

  // Multiplier walks the multiplier LSB-first while the multiplicand shifts
  // left; only the low WIDTH bits of the product are ever needed.
  assign acc_nxt = acc + (mp[0] ? mc : '0);

  always_comb begin
    reject = 1'b0;
    if (push) begin
      reject = full;
    end else begin
      case (op)
        OP_NOP:                         reject = 1'b0;
        OP_NEG, OP_DROP:                reject = empty;
        OP_DUP:                         reject = empty || full;
        OP_ADD, OP_MUL, OP_SUB, OP_SWAP: reject = (cnt < CW'(2));
        default:                        reject = 1'b0;
      endcase
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = t_idx;
    mem_wd = top;
    if (accept && !reject) begin
      if (push) begin
        mem_we = !empty;
      end else if (op == OP_DUP) begin
        mem_we = 1'b1;
      end else if (op == OP_SWAP) begin
        mem_we = 1'b1;
        mem_wa = s_idx;
      end
    end
  end

  // Stack storage is deliberately not reset; cnt=0 hides stale contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      top   <= '0;
      out   <= '0;
      err   <= 1'b0;
      mc    <= '0;
      mp    <= '0;
      acc   <= '0;
      step  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (reject) begin
              err <= 1'b1;
            end else if (push) begin
              top <= d;
              out <= d;
              cnt <= cnt + CW'(1);
            end else begin
              case (op)
                OP_NOP: begin
                  out <= empty ? '0 : top;
                end
                OP_NEG: begin
                  top <= -top;
                  out <= -top;
                end
                OP_ADD: begin
                  top <= s_val + top;
                  out <= s_val + top;
                  cnt <= cnt - CW'(1);
                end
                OP_SUB: begin
                  top <= s_val - top;
                  out <= s_val - top;
                  cnt <= cnt - CW'(1);
                end
                OP_MUL: begin
                  mc    <= s_val;
                  mp    <= top;
                  acc   <= '0;
                  step  <= '0;
                  state <= MUL;
                end
                OP_DUP: begin
                  out <= top;
                  cnt <= cnt + CW'(1);
                end
                OP_SWAP: begin
                  top <= s_val;
                  out <= s_val;
                end
                OP_DROP: begin
                  top <= s_val;
                  out <= (cnt == CW'(1)) ? '0 : s_val;
                  cnt <= cnt - CW'(1);
                end
                default: begin
                  out <= out;
                end
              endcase
            end
          end
        end
        MUL: begin
          acc  <= acc_nxt;
          mc   <= mc << 1;
          mp   <= mp >> 1;
          step <= step + SW'(1);
          // The last step commits the product in the same edge it is formed.
          if (step == SW'(WIDTH - 1)) begin
            state <= IDLE;
            top   <= acc_nxt;
            out   <= acc_nxt;
            cnt   <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rpn_stack_calc.md
# rpn_stack_calc

Parametrised reverse-Polish stack calculator: the successor to the fixed 16-bit, 1024-entry push/neg/add/mul stack. It adds configurable width and depth, subtract and stack-manipulation ops, a valid/ready command handshake and a sequential shift-add multiplier. Underflow and overflow are detected and reported with a sticky error flag. It sits behind a command source (keypad decoder or test driver) and drives the display and readback path with the current top of stack.

## Interface
- WIDTH, 16, data and operand width in bits (≥2)
- DEPTH, 1024, stack entries; power of two, ≥4
- Derived CW = $clog2(DEPTH)+1, width of cnt; it can represent a full stack
- clk  in  1  single clock; all state changes on rising edge
- nrst  in  1  asynchronous, active-low reset
- valid  in  1  command present this cycle
- ready  out  1  block can accept a command this cycle
- push  in  1  1: push d; 0: execute op (push has priority)
- op  in  3  opcode, used when push=0
- d  in  WIDTH  push operand
- out  out  WIDTH  registered copy of current top of stack; 0 when empty
- cnt  out  CW  number of entries on stack
- err  out  1  sticky: set by any rejected command, cleared only by reset

## Operation
- A command is accepted on a rising edge with valid && ready. With valid=0 or ready=0 no state changes.
- T = top entry, S = second entry. All arithmetic is modulo 2^WIDTH, two's complement, with no flags on wrap.
- PUSH: requires cnt<DEPTH. New T=d, cnt+1.
- Opcodes, with the minimum cnt each needs:
  - 000 NOP (0): no stack change; out refreshed to T (0 if empty).
  - 001 NEG (1): T ← −T.
  - 010 ADD (2): pop 2, push S+T; cnt−1.
  - 011 MUL (2): pop 2, push low WIDTH bits of S*T; cnt−1; multi-cycle.
  - 100 SUB (2): pop 2, push S−T; cnt−1.
  - 101 DUP (1; also needs cnt<DEPTH): push copy of T; cnt+1.
  - 110 SWAP (2): exchange T and S; cnt unchanged.
  - 111 DROP (1): cnt−1.
- Rejected command (minimum cnt not met, or push/DUP when full):
  - err←1.
  - cnt, stack contents and out unchanged.
  - ready stays 1.
  - The command still counts as consumed.
- out: after every accepted command that is not rejected, out = new T, or 0 if cnt becomes 0.
- Multiplier FSM, states IDLE and MUL:
  - IDLE→MUL on an accepted valid MUL. S and T are latched into the operand registers and the accumulator is cleared.
  - MUL: one shift-add step per cycle, WIDTH steps total.
  - MUL→IDLE on the final step. That same edge writes the product to the stack, decrements cnt and updates out.
  - ready = (state==IDLE).
- Stack storage: one DEPTH×WIDTH array. The implementation may hold T and/or S in registers. Contents are not reset; cnt=0 makes them invisible.

## Timing
- Reset (nrst low, asynchronous): cnt=0, out=0, err=0, ready=1, FSM=IDLE.
- Reset during MUL aborts it: no stack write, ready=1 immediately while nrst is low.
- First command is accepted on the first rising edge after nrst deasserts.
- Non-MUL commands: out and cnt are valid after the accepting edge (1-cycle latency). Back-to-back commands are allowed every cycle.
- MUL accepted on edge E0:
  - ready=0 after E0.
  - Result, cnt−1 and ready=1 all appear after edge E0+WIDTH.
  - The next command can be accepted on edge E0+WIDTH+1.
- valid held high with ready=0 is ignored. The source holds the command until ready is seen high at an edge.
- A rejected MUL does not enter the MUL state (ready never drops).
- A new PUSH during MUL is not possible (ready=0).

## Test plan
- Reset/basic: WIDTH=16, DEPTH=4. Push 5, push 7, ADD.
  - Expect cnt=1 and out=12, one cycle after ADD.
  - Then NEG gives out=0xFFF4.
- Sub/swap: push 10, push 3, SWAP, SUB.
  - Expect out=0xFFF9 (3−10), cnt=1, err=0.
- Multiplier: push 300, push 300, MUL.
  - Expect ready low for exactly 16 cycles.
  - Then out=0x5F90 (90000 mod 65536), cnt=1.
  - valid held high during busy causes no change.
- Bounds: DEPTH=4. Push 1,2,3,4, then push 9 → err=1, cnt=4, out=4. DUP also rejected.
  - Drop ×4 → cnt=0, out=0.
  - ADD on empty stack → cnt=0, err stays 1.
- Reset mid-MUL: push 3, push 4, MUL, assert nrst at busy cycle 5.
  - Expect cnt=0, out=0, err=0, ready=1 asynchronously.
  - After release, push 2 → out=2, cnt=1.
- Wrap: push 0x8000, push 0x8000, ADD → out=0x0000, err=0.
